// File: rtl/stack_data_memory_pkg.sv
// Shared types for the stack-capable data memory.
// Fault cause codes reported alongside the one-cycle fault pulse.
package mem_pkg;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    WR_PROT   = 3'd1,
    OVERFLOW  = 3'd2,
    UNDERFLOW = 3'd3,
    MULTI_CMD = 3'd4
  } fault_code_e;

endpackage

// File: rtl/stack_data_memory_if.sv
// MEM-stage command/response bundle for the stack data memory.
// Master is the control unit side, slave is the memory.
interface stack_data_memory_if
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     addr;
  logic              rd_en;
  logic              wr_en;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [AW:0]       sp;
  logic              full;
  logic              empty;
  logic              fault;
  fault_code_e       fault_code;

  modport master (
    output addr, rd_en, wr_en, push, pop, wdata,
    input  rdata, rvalid, sp, full, empty,
    input  fault, fault_code
  );

  modport slave (
    input  addr, rd_en, wr_en, push, pop, wdata,
    output rdata, rvalid, sp, full, empty,
    output fault, fault_code
  );
endinterface

// File: rtl/stack_data_memory_ram.sv
// Single-port synchronous RAM, registered read, no reset.
module stack_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/stack_data_memory.sv
// Data memory with a hardware-managed upward-growing stack region.
// Owns sp, flags illegal commands with a registered cause code.
module stack_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int STACK_BASE = DEPTH / 2
) (
  input logic           clk,
  input logic           rst_n,
  stack_data_memory_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_BASE = (AW+1)'(STACK_BASE);
  localparam logic [AW:0] SP_TOP  = (AW+1)'(DEPTH);

  logic [AW:0]       r_sp;
  logic              r_rvalid;
  logic              r_fault;
  logic              r_has_data;
  fault_code_e       r_fault_code;

  logic [2:0]        w_ncmd;
  logic              w_multi;
  logic              w_full;
  logic              w_empty;
  logic              w_in_data;
  logic              w_rd;
  logic              w_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_we;
  logic              w_re;
  logic [AW-1:0]     w_top_addr;
  logic [AW-1:0]     w_ram_addr;
  logic [DATA_W-1:0] w_ram_q;
  fault_code_e       w_fcode;

  assign w_ncmd = 3'(bus.rd_en) + 3'(bus.wr_en)
                + 3'(bus.push) + 3'(bus.pop);
  assign w_multi   = w_ncmd > 3'd1;
  assign w_full    = r_sp == SP_TOP;
  assign w_empty   = r_sp == SP_BASE;
  assign w_in_data = {1'b0, bus.addr} < SP_BASE;

  assign w_rd   = bus.rd_en & ~w_multi;
  assign w_wr   = bus.wr_en & ~w_multi & w_in_data;
  assign w_push = bus.push & ~w_multi & ~w_full;
  assign w_pop  = bus.pop & ~w_multi & ~w_empty;

  // Reset overrides any command, including the RAM side
  assign w_we = rst_n & (w_wr | w_push);
  assign w_re = rst_n & (w_rd | w_pop);

  assign w_top_addr = r_sp[AW-1:0] - AW'(1);

  always_comb begin
    w_ram_addr = bus.addr;
    unique case (1'b1)
      w_push:  w_ram_addr = r_sp[AW-1:0];
      w_pop:   w_ram_addr = w_top_addr;
      default: w_ram_addr = bus.addr;
    endcase
  end

  always_comb begin
    w_fcode = NONE;
    unique case (1'b1)
      w_multi:                          w_fcode = MULTI_CMD;
      ~w_multi & bus.wr_en & ~w_in_data: w_fcode = WR_PROT;
      ~w_multi & bus.push & w_full:     w_fcode = OVERFLOW;
      ~w_multi & bus.pop & w_empty:     w_fcode = UNDERFLOW;
      default:                          w_fcode = NONE;
    endcase
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_ram_addr),
    .i_wdata (bus.wdata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp         <= SP_BASE;
      r_rvalid     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= NONE;
      r_has_data   <= 1'b0;
    end else begin
      r_rvalid     <= w_re;
      r_fault      <= w_fcode != NONE;
      r_fault_code <= w_fcode;
      if (w_re) r_has_data <= 1'b1;
      if (w_push) r_sp <= r_sp + (AW+1)'(1);
      else if (w_pop) r_sp <= r_sp - (AW+1)'(1);
    end
  end

  // RAM has no reset, so mask its output until the first read
  assign bus.rdata      = r_has_data ? w_ram_q : '0;
  assign bus.rvalid     = r_rvalid;
  assign bus.sp         = r_sp;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
endmodule

// File: tb/tb_stack_data_memory.sv
// Randomized bench for stack_data_memory against a behavioural model.
module tb_stack_data_memory;
  import mem_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int SB     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_data_memory_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  stack_data_memory #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .STACK_BASE (SB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] m_mem [DEPTH];
  int          m_sp;
  logic [31:0] m_rdata;
  bit          m_rvalid;
  int          m_code;

  int errors = 0;
  int checks = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit rst, bit rd, bit wr, bit ps, bit pp,
                      int a, logic [31:0] d);
    int n;
    rst_n      = ~rst;
    bus.rd_en  = rd;
    bus.wr_en  = wr;
    bus.push   = ps;
    bus.pop    = pp;
    bus.addr   = a[3:0];
    bus.wdata  = d;
    @(posedge clk);
    #1;
    n = int'(rd) + int'(wr) + int'(ps) + int'(pp);
    m_rvalid = 0;
    m_code   = 0;
    if (rst) begin
      m_sp    = SB;
      m_rdata = '0;
    end else if (n > 1) begin
      m_code = 4;
    end else if (rd) begin
      m_rdata  = m_mem[a];
      m_rvalid = 1;
    end else if (wr) begin
      if (a < SB) m_mem[a] = d;
      else m_code = 1;
    end else if (ps) begin
      if (m_sp < DEPTH) begin
        m_mem[m_sp] = d;
        m_sp++;
      end else m_code = 2;
    end else if (pp) begin
      if (m_sp > SB) begin
        m_sp--;
        m_rdata  = m_mem[m_sp];
        m_rvalid = 1;
      end else m_code = 3;
    end
    check("sp", 64'(bus.sp), 64'(m_sp));
    check("full", 64'(bus.full), 64'(m_sp == DEPTH));
    check("empty", 64'(bus.empty), 64'(m_sp == SB));
    check("rvalid", 64'(bus.rvalid), 64'(m_rvalid));
    check("rdata", 64'(bus.rdata), 64'(m_rdata));
    check("fault", 64'(bus.fault), 64'(m_code != 0));
    check("fcode", 64'(int'(bus.fault_code)), 64'(m_code));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    bus.rd_en = 0;
    bus.wr_en = 0;
    bus.push  = 0;
    bus.pop   = 0;
    bus.addr  = '0;
    bus.wdata = '0;

    step(1, 0, 0, 0, 0, 0, 32'h0);
    check("rst_rdata", 64'(bus.rdata), 64'h0);

    // Give every word a known value
    for (int i = 0; i < SB; i++) step(0, 0, 1, 0, 0, i, $urandom);
    for (int i = 0; i < SB; i++) step(0, 0, 0, 1, 0, 0, $urandom);
    for (int i = 0; i < SB; i++) step(0, 0, 0, 0, 1, 0, 32'h0);

    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 4, 32'h12345678);
    step(0, 1, 0, 0, 0, 4, 32'h0);
    check("tp_rd4", 64'(bus.rdata), 64'h12345678);

    step(0, 0, 1, 0, 0, 9, 32'hDEADBEEF);
    check("tp_wrprot", 64'(int'(bus.fault_code)), 64'(int'(WR_PROT)));
    step(0, 1, 0, 0, 0, 9, 32'h0);

    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0, 32'hA0 + i);
    check("tp_full", 64'(bus.full), 64'h1);
    step(0, 0, 0, 1, 0, 0, 32'hA8);
    check("tp_ovf", 64'(int'(bus.fault_code)), 64'(int'(OVERFLOW)));
    step(0, 1, 0, 0, 0, 15, 32'h0);
    check("tp_rd15", 64'(bus.rdata), 64'hA7);

    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, 0, 32'h0);
      check("tp_pop", 64'(bus.rdata), 64'(32'hA7 - i));
    end
    step(0, 0, 0, 0, 1, 0, 32'h0);
    check("tp_unf", 64'(int'(bus.fault_code)), 64'(int'(UNDERFLOW)));
    check("tp_hold", 64'(bus.rdata), 64'hA0);

    step(0, 1, 0, 1, 0, 3, 32'h55);
    check("tp_multi", 64'(int'(bus.fault_code)), 64'(int'(MULTI_CMD)));

    step(0, 0, 0, 1, 0, 0, 32'hC0FFEE01);
    step(0, 0, 0, 1, 0, 0, 32'hC0FFEE02);
    step(1, 0, 0, 0, 1, 0, 32'h0);
    check("tp_rst_sp", 64'(bus.sp), 64'd8);
    step(0, 1, 0, 0, 0, 8, 32'h0);
    check("tp_retain", 64'(bus.rdata), 64'hC0FFEE01);
    idle();

    for (int it = 0; it < 600; it++) begin
      int r;
      int sel;
      bit b[4];
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1, 0, 0, 0, 0, 0, 32'h0);
      end else if (r < 9) begin
        b[0] = 0; b[1] = 0; b[2] = 0; b[3] = 0;
        b[$urandom_range(0, 3)] = 1;
        b[$urandom_range(0, 3)] = 1;
        b[$urandom_range(0, 3)] = 1;
        step(0, b[0], b[1], b[2], b[3],
             $urandom_range(0, 15), $urandom);
      end else begin
        sel = $urandom_range(0, 4);
        step(0, sel == 1, sel == 2, sel == 3, sel == 4,
             $urandom_range(0, 15), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stack_data_memory.md
# stack_data_memory

Parametrised word-addressed data memory with a hardware-managed LIFO stack region, the successor to the processor's combined data/stack memory. The lower region serves normal load/store and the upper region is reachable only through push/pop. The block owns the stack pointer itself, reports full/empty, and flags every illegal access with a cause code instead of silently dropping it. It sits in the MEM stage, driven by the control unit's memory-command signals.

## Interface
- DATA_W, 32, word width in bits
- DEPTH, 16, total words (power of two, ≥4)
- STACK_BASE, DEPTH/2, first word of the stack region; data region is [0, STACK_BASE), stack region is [STACK_BASE, DEPTH)
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- addr  in  AW  word address for rd_en/wr_en
- rd_en  in  1  normal read
- wr_en  in  1  normal write
- push  in  1  push wdata onto stack
- pop  in  1  pop top of stack into rdata
- wdata  in  DATA_W  write/push data
- rdata  out  DATA_W  read/pop data, registered
- rvalid  out  1  rdata updated this cycle
- sp  out  AW+1  next-free stack slot
- full  out  1  sp == DEPTH
- empty  out  1  sp == STACK_BASE
- fault  out  1  one-cycle pulse: command rejected
- fault_code  out  3  cause, valid while fault=1

## Operation
- Commands are sampled at the rising edge. At most one of rd_en/wr_en/push/pop may be high; none high means idle.
- Read: rdata ← mem[addr], rvalid=1. Any address is legal, including the stack region (debug visibility).
- Write: if addr < STACK_BASE, mem[addr] ← wdata. Otherwise there is no write, and the block raises fault with WR_PROT.
- Push: if not full, mem[sp] ← wdata and sp ← sp+1. If full, there is no write, sp is unchanged, and fault is raised with OVERFLOW.
- Pop: if not empty, rdata ← mem[sp−1], sp ← sp−1, rvalid=1. If empty, rdata holds, rvalid=0, and fault is raised with UNDERFLOW.
- Two or more command bits high: no memory, sp or rdata change, and fault is raised with MULTI_CMD.
- The stack grows upward. sp is AW+1 bits wide, so the value DEPTH is representable.
- full and empty are combinational from sp.

## Timing
- Reset (rst_n=0 at an edge) overrides any command in that cycle. Results after reset: sp=STACK_BASE, empty=1, full=0, rdata=0, rvalid=0, fault=0, fault_code=NONE.
- Reset does not clear memory contents.
- Read/pop latency is 1 cycle. A command at edge N produces rdata/rvalid after edge N; rvalid is high for exactly one cycle.
- rdata holds its value until the next successful read or pop.
- Write/push commit at edge N. A read of the same address at edge N+1 returns the new data.
- sp/full/empty reflect a push/pop immediately after edge N.
- fault/fault_code are registered and high for exactly one cycle after the offending edge. fault_code returns to NONE otherwise.
- Back-to-back commands are legal every cycle with no bubbles.
- Push at sp=DEPTH−1 succeeds, and full asserts after that edge.
- Pop at sp=STACK_BASE+1 succeeds, and empty asserts after that edge.

## Structure
- Shared package mem_pkg holds fault_code enum: NONE=0, WR_PROT=1, OVERFLOW=2, UNDERFLOW=3, MULTI_CMD=4.
- Sub-module stack_ram: single-port synchronous RAM (DATA_W×DEPTH, one write port, registered read, no reset).
- Top level holds command decode, sp register, fault logic and the address mux (addr vs sp vs sp−1).

## Test plan
(DEPTH=16, STACK_BASE=8)
- Reset, then write 0x12345678 to addr 4, then read addr 4. Expected: rdata=0x12345678 and rvalid=1 one cycle after the read; fault stays 0.
- Write 0xDEADBEEF to addr 9. Expected: fault=1 with WR_PROT; a subsequent read of addr 9 returns the pre-test contents.
- Push 0xA0…0xA7 on eight consecutive cycles. Expected: sp goes 8→16 and full=1. A ninth push gives OVERFLOW with sp=16; a read of addr 15 returns 0xA7.
- Pop eight times. Expected: rdata sequence 0xA7…0xA0, each with rvalid=1, ending at sp=8 and empty=1. A ninth pop gives UNDERFLOW, rvalid=0, and rdata holds 0xA0.
- Assert push and rd_en together. Expected: MULTI_CMD, sp unchanged, rvalid=0.
- Push twice, then assert rst_n=0 coincident with a pop. Expected: sp=8, empty=1, rdata=0, no fault. Memory retains the pushed words, verified by a read of addr 8.
